// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline constants and the M/W stage bundle used by the
// writeback stage and the hazard unit.
package rv32i_pkg;

    localparam int unsigned DPW                = 32;
    localparam int unsigned RF_ADW             = 5;
    localparam int unsigned DMEM_WORDS_DEFAULT = 256;

    // Per-stage bundle carried through EX/MEM and MEM/WB.
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              resultsrc;
        logic [DPW-1:0]    aluresult;
        logic [RF_ADW-1:0] rd;
    } mw_bundle_t;

endpackage

// File: rtl/writeback_stage_data_mem.sv
// Word-addressed data memory: combinational read, write on rising edge.
module data_mem #(
    parameter int unsigned DMEM_WORDS = 256,
    parameter int unsigned DPW        = 32,
    localparam int unsigned AW        = $clog2(DMEM_WORDS)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  addr,
    input  logic [DPW-1:0] wd,
    output logic [DPW-1:0] rd
);

    logic [DPW-1:0] mem [DMEM_WORDS];

    // Synchronous word write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wd;
        end
    end

    assign rd = mem[addr];

endmodule

// File: rtl/writeback_stage.sv
// Memory and writeback stages of the RV32I pipeline: EX/MEM register, data
// memory, MEM/WB register, register-file write port and retired counter.
module writeback_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned ADW        = 5,
    parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           validE,
    input  logic           regwriteE,
    input  logic           resultsrcE,
    input  logic           memwriteE,
    input  logic [DPW-1:0] aluresultE,
    input  logic [DPW-1:0] writedataE,
    input  logic [ADW-1:0] RdE,
    output logic [DPW-1:0] aluresultM,
    output logic [ADW-1:0] RdM,
    output logic           regwriteM,
    output logic [ADW-1:0] RdW,
    output logic           regwriteW,
    output logic [ADW-1:0] addr_3,
    output logic [DPW-1:0] wd_3,
    output logic           we,
    output logic [31:0]    instret
);

    localparam int unsigned IW = $clog2(DMEM_WORDS);

    mw_bundle_t     m_q;
    mw_bundle_t     w_q;
    logic           memwrite_m_q;
    logic [DPW-1:0] writedata_m_q;
    logic [DPW-1:0] readdata_m;
    logic [DPW-1:0] readdata_w_q;
    logic [31:0]    instret_q;

    // EX/MEM register; control bits are qualified by validE so bubbles are inert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q           <= '0;
            memwrite_m_q  <= 1'b0;
            writedata_m_q <= '0;
        end else begin
            m_q.valid     <= validE;
            m_q.regwrite  <= regwriteE & validE;
            m_q.resultsrc <= resultsrcE;
            m_q.aluresult <= aluresultE;
            m_q.rd        <= RF_ADW'(RdE);
            memwrite_m_q  <= memwriteE & validE;
            writedata_m_q <= writedataE;
        end
    end

    // Low two address bits dropped (word access); upper bits wrap.
    data_mem #(
        .DMEM_WORDS (DMEM_WORDS),
        .DPW        (DPW)
    ) u_data_mem (
        .clk  (clk),
        .we   (memwrite_m_q),
        .addr (m_q.aluresult[IW+1:2]),
        .wd   (writedata_m_q),
        .rd   (readdata_m)
    );

    // MEM/WB register; load data is the pre-write value for a store slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q          <= '0;
            readdata_w_q <= '0;
        end else begin
            w_q          <= m_q;
            readdata_w_q <= readdata_m;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (w_q.valid) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign aluresultM = m_q.aluresult;
    assign RdM        = ADW'(m_q.rd);
    assign regwriteM  = m_q.regwrite;
    assign RdW        = ADW'(w_q.rd);
    assign regwriteW  = w_q.regwrite;

    // Register-file write port; writes to x0 are suppressed.
    assign addr_3  = ADW'(w_q.rd);
    assign wd_3    = w_q.resultsrc ? readdata_w_q : w_q.aluresult;
    assign we      = w_q.regwrite & (w_q.rd != '0);
    assign instret = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        validE, regwriteE, resultsrcE, memwriteE;
    logic [31:0] aluresultE, writedataE;
    logic [4:0]  RdE;
    logic [31:0] aluresultM;
    logic [4:0]  RdM;
    logic        regwriteM;
    logic [4:0]  RdW;
    logic        regwriteW;
    logic [4:0]  addr_3;
    logic [31:0] wd_3;
    logic        we;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;

    writeback_stage #(
        .ADW        (5),
        .DMEM_WORDS (256)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .validE     (validE),
        .regwriteE  (regwriteE),
        .resultsrcE (resultsrcE),
        .memwriteE  (memwriteE),
        .aluresultE (aluresultE),
        .writedataE (writedataE),
        .RdE        (RdE),
        .aluresultM (aluresultM),
        .RdM        (RdM),
        .regwriteM  (regwriteM),
        .RdW        (RdW),
        .regwriteW  (regwriteW),
        .addr_3     (addr_3),
        .wd_3       (wd_3),
        .we         (we),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic rs, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wdat, input logic [4:0] rd);
        validE     = v;
        regwriteE  = rw;
        resultsrcE = rs;
        memwriteE  = mw;
        aluresultE = alu;
        writedataE = wdat;
        RdE        = rd;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bubble();
        #12;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset: busy pipeline, reset pulsed mid-cycle clears everything at once.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0055, 5'd3);
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_addr_3", {27'd0, addr_3}, 32'd0);
        check("rst_wd_3", wd_3, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_regwriteM", {31'd0, regwriteM}, 32'd0);
        check("rst_RdM", {27'd0, RdM}, 32'd0);
        check("rst_aluresultM", aluresultM, 32'd0);
        bubble();
        @(negedge clk);
        rst_n = 1'b1;

        // ALU writeback to x5.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
        step();
        check("alu_regwriteM", {31'd0, regwriteM}, 32'd1);
        check("alu_RdM", {27'd0, RdM}, 32'd5);
        check("alu_aluresultM", aluresultM, 32'h0000_1234);
        bubble();
        step();
        check("alu_addr_3", {27'd0, addr_3}, 32'd5);
        check("alu_wd_3", wd_3, 32'h0000_1234);
        check("alu_we", {31'd0, we}, 32'd1);
        check("alu_instret_pre", instret, 32'd0);
        step();
        check("alu_we_one_cycle", {31'd0, we}, 32'd0);
        check("alu_instret", instret, 32'd1);

        // Store then back-to-back loads, including ignored low bits and wrap.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 5'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd7);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0041, 32'h0, 5'd8);
        step();
        check("ld40_addr_3", {27'd0, addr_3}, 32'd7);
        check("ld40_wd_3", wd_3, 32'hDEAD_BEEF);
        check("ld40_we", {31'd0, we}, 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0440, 32'h0, 5'd9);
        step();
        check("ld41_addr_3", {27'd0, addr_3}, 32'd8);
        check("ld41_wd_3", wd_3, 32'hDEAD_BEEF);
        bubble();
        step();
        check("ld440_addr_3", {27'd0, addr_3}, 32'd9);
        check("ld440_wd_3", wd_3, 32'hDEAD_BEEF);
        step();
        check("ld_instret", instret, 32'd5);

        // Write to x0 retires but never asserts we.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd0);
        step();
        bubble();
        step();
        check("x0_we", {31'd0, we}, 32'd0);
        check("x0_regwriteW", {31'd0, regwriteW}, 32'd1);
        step();
        check("x0_instret", instret, 32'd6);

        // Bubble with all control bits set is inert.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 5'd4);
        step();
        check("bub_regwriteM", {31'd0, regwriteM}, 32'd0);
        bubble();
        step();
        check("bub_we", {31'd0, we}, 32'd0);
        step();
        check("bub_instret", instret, 32'd6);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd10);
        step();
        bubble();
        step();
        check("bub_mem_kept", wd_3, 32'hDEAD_BEEF);
        check("bub_ld_addr_3", {27'd0, addr_3}, 32'd10);

        // Reset while a store sits in M discards that store.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_0001, 5'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h0BAD_0002, 5'd0);
        step();
        #2;
        rst_n = 1'b0;
        bubble();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 5'd11);
        step();
        bubble();
        step();
        check("rstst_addr_3", {27'd0, addr_3}, 32'd11);
        check("rstst_wd_3", wd_3, 32'hCAFE_0001);
        step();
        check("rstst_instret", instret, 32'd1);

        // Counter wrap via a deposit into the counter register.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("wrap_preload", instret, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0, 5'd1);
        step();
        bubble();
        step();
        check("wrap_hold", instret, 32'hFFFF_FFFF);
        step();
        check("wrap_zero", instret, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Back end of the RV32I pipeline: takes the execute-stage result bundle through the memory stage (EX/MEM register plus data memory) and the writeback stage (MEM/WB register).
- Drives the register-file write port (addr_3, wd_3, we) consumed by the execute_stage block.
- Exports M/W destination information to the hazard unit for forwarding, and keeps a retired-instruction counter.

Parameters:
ADW, 5, register address width
DMEM_WORDS, 256, data memory depth in 32-bit words (power of two)
(DPW, 32, datapath width, taken from rv32i_pkg)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
validE  input  1  execute-stage slot holds a real instruction (0 = bubble)
regwriteE  input  1  instruction writes rd
resultsrcE  input  1  0 = ALU result to rd, 1 = load data to rd
memwriteE  input  1  store instruction
aluresultE  input  DPW  ALU result / effective byte address
writedataE  input  DPW  store data (forwarded rs2)
RdE  input  ADW  destination register
aluresultM  output  DPW  M-stage ALU result (forwarding source)
RdM  output  ADW  M-stage destination
regwriteM  output  1  M-stage write enable (valid-qualified)
RdW  output  ADW  W-stage destination
regwriteW  output  1  W-stage write enable (valid-qualified)
addr_3  output  ADW  register-file write address
wd_3  output  DPW  register-file write data
we  output  1  register-file write enable
instret  output  32  retired-instruction count

Behaviour:
- Reset (rst_n low, async): all EX/MEM and MEM/WB fields clear to 0. Outputs: we=0, addr_3=0, wd_3=0, regwriteM=0, regwriteW=0, RdM=0, RdW=0, aluresultM=0, instret=0. Data memory contents are not reset.
- EX/MEM register (each edge): validM<=validE. regwriteM/memwriteM <= corresponding E bit AND validE. resultsrcM, aluresultM, writedataM, RdM <= E values.
- Data memory: word index = aluresultM[log2(DMEM_WORDS)+1:2].
  - Low two address bits ignored (word access only); upper bits ignored, so addresses wrap modulo 4*DMEM_WORDS.
  - Read is combinational: readdataM = mem[index].
  - Write occurs at the rising edge when memwriteM=1.
- MEM/WB register (each edge): validW, regwriteW, resultsrcW, aluresultW, RdW <= M values. readdataW <= readdataM, i.e. the pre-write value when the same slot is a store.
- Write port (combinational from W):
  - addr_3 = RdW.
  - wd_3 = resultsrcW ? readdataW : aluresultW.
  - we = regwriteW AND (RdW != 0); x0 writes are suppressed.
- Latency: instruction presented on E inputs before edge N is in M after N, in W after N+1. Its register write is presented on addr_3/wd_3/we during cycle N+1 to N+2.
- Store then load to the same address in consecutive slots: the load (in M one cycle after the store's commit edge) reads the new data.
- instret: increments by 1 at each edge where validW=1. Wraps 0xFFFF_FFFF -> 0.
- Bubbles (validE=0): no memory write, no register write, no instret increment, even if the control bits are 1.
- Reset asserted mid-operation: the in-flight store in M is discarded (memwriteM forced to 0 asynchronously), no write occurs. After release, the pipeline restarts empty.
- No stall input; the stage advances every cycle.

Decomposition:
- rv32i_pkg: DPW (existing), add DMEM_WORDS_DEFAULT constant.
- A packed struct typedef for the M/W pipeline bundle (valid, regwrite, resultsrc, aluresult, rd) shared with the hazard unit.
- Sub-module data_mem: parameters DMEM_WORDS and DPW; ports clk, we, addr, wd, rd; combinational read, synchronous write.
- The two pipeline registers and the result mux stay in writeback_stage.

Test Plan:
- Reset: drive all inputs nonzero, pulse rst_n low mid-cycle -> immediately we=0, addr_3=0, wd_3=0, instret=0, regwriteM=0.
- ALU writeback: validE=1, regwriteE=1, resultsrcE=0, aluresultE=0x0000_1234, RdE=5 -> two edges later addr_3=5, wd_3=0x1234, we=1 for exactly one cycle; instret=1.
- Store/load: store 0xDEAD_BEEF at aluresult 0x40, next slot load (resultsrcE=1, RdE=7) from 0x40 -> wd_3=0xDEAD_BEEF, addr_3=7, we=1. Load from 0x41 returns the same word. Load from 0x440 with DMEM_WORDS=256 also returns the same word (wrap).
- x0 and bubble: regwriteE=1, RdE=0 -> we=0, instret increments. validE=0 with regwriteE=1, memwriteE=1 -> no memory change, we=0, instret unchanged.
- Reset mid-store: store to 0x80 in M, assert rst_n before the edge -> a later load of 0x80 returns the prior content.
- Counter wrap: force instret to 0xFFFF_FFFF through a preloaded sequence, or by a bench-only deposit, then retire one instruction -> instret=0.
